// File: rtl/input_mapper_if.sv
// Key/joystick input words and per-player control outputs
// between hps_io (master) and the input mapper (slave).
interface input_mapper_if;
    logic [10:0] ps2_key;
    logic [31:0] joystick_0;
    logic [31:0] joystick_1;
    logic [9:0]  player1;
    logic [9:0]  player2;
    logic [1:0]  service;

    modport master (
        output ps2_key, joystick_0, joystick_1,
        input  player1, player2, service
    );

    modport slave (
        input  ps2_key, joystick_0, joystick_1,
        output player1, player2, service
    );
endinterface

// File: rtl/input_mapper.sv
// Maps PS/2 key events and MiSTer joysticks onto registered
// per-player arcade controls with coin stretch and pause toggle.
module input_mapper #(
    parameter int unsigned COIN_PULSE_CYCLES = 4800000,
    parameter bit          PAUSE_TOGGLE      = 1'b1
) (
    input logic           clk,
    input logic           rst_n,
    input_mapper_if.slave io
);
    localparam int CW = $clog2(COIN_PULSE_CYCLES + 1);
    localparam logic [CW-1:0] RELOAD = CW'(COIN_PULSE_CYCLES - 1);

    // Joystick {.. pause,coin,start,b3,b2,b1,U,D,L,R} -> output layout
    function automatic logic [9:0] map_joy(input logic [9:0] j);
        return {j[9], j[8], j[7], j[6], j[5], j[4],
                j[0], j[1], j[2], j[3]};
    endfunction

    logic          old_toggle;
    logic          ev;
    logic          mk;
    logic [7:0]    code;
    logic [9:0]    p1_key;
    logic [8:0]    p2_key;
    logic [1:0]    svc_key;
    logic [9:0]    raw1;
    logic [9:0]    raw2;
    logic [1:0]    raw_svc;
    logic [1:0]    raw_coin;
    logic [1:0]    raw_pause;
    logic [1:0]    coin_prev;
    logic [1:0]    coin_rise;
    logic [1:0]    pause_prev;
    logic [1:0]    pause_rise;
    logic [1:0]    pause_q;
    logic [1:0]    pause_nxt;
    logic [1:0]    coin_q;
    logic [CW-1:0] cnt [2];
    logic [7:0]    p1_q;
    logic [7:0]    p2_q;
    logic [1:0]    svc_q;

    wire unused_bits = ^{io.joystick_0[31:11],
                         io.joystick_1[31:11],
                         io.ps2_key[8]};

    assign ev   = io.ps2_key[10] != old_toggle;
    assign mk   = io.ps2_key[9];
    assign code = io.ps2_key[7:0];

    assign raw1    = p1_key | map_joy(io.joystick_0[9:0]);
    assign raw2    = {1'b0, p2_key} | map_joy(io.joystick_1[9:0]);
    assign raw_svc = svc_key | {io.joystick_1[10], io.joystick_0[10]};

    assign raw_coin   = {raw2[8], raw1[8]};
    assign raw_pause  = {raw2[9], raw1[9]};
    assign coin_rise  = raw_coin & ~coin_prev;
    assign pause_rise = raw_pause & ~pause_prev;

    always_comb begin
        pause_nxt = raw_pause;
        if (PAUSE_TOGGLE)
            pause_nxt = pause_q ^ pause_rise;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            old_toggle <= io.ps2_key[10];
            p1_key     <= '0;
            p2_key     <= '0;
            svc_key    <= '0;
        end else begin
            old_toggle <= io.ps2_key[10];
            if (ev) begin
                case (code)
                    8'h75:   p1_key[0]  <= mk;
                    8'h72:   p1_key[1]  <= mk;
                    8'h6B:   p1_key[2]  <= mk;
                    8'h74:   p1_key[3]  <= mk;
                    8'h14:   p1_key[4]  <= mk;
                    8'h11:   p1_key[5]  <= mk;
                    8'h29:   p1_key[6]  <= mk;
                    8'h16:   p1_key[7]  <= mk;
                    8'h2E:   p1_key[8]  <= mk;
                    8'h4D:   p1_key[9]  <= mk;
                    8'h2D:   p2_key[0]  <= mk;
                    8'h2B:   p2_key[1]  <= mk;
                    8'h23:   p2_key[2]  <= mk;
                    8'h34:   p2_key[3]  <= mk;
                    8'h1C:   p2_key[4]  <= mk;
                    8'h1B:   p2_key[5]  <= mk;
                    8'h15:   p2_key[6]  <= mk;
                    8'h1E:   p2_key[7]  <= mk;
                    8'h36:   p2_key[8]  <= mk;
                    8'h46:   svc_key[0] <= mk;
                    8'h45:   svc_key[1] <= mk;
                    default: ;
                endcase
            end
        end
    end

    // Coin stretch: a rise reloads, otherwise count down to 0
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            coin_prev  <= '0;
            pause_prev <= '0;
            pause_q    <= '0;
            coin_q     <= '0;
            p1_q       <= '0;
            p2_q       <= '0;
            svc_q      <= '0;
            for (int i = 0; i < 2; i++)
                cnt[i] <= '0;
        end else begin
            coin_prev  <= raw_coin;
            pause_prev <= raw_pause;
            pause_q    <= pause_nxt;
            p1_q       <= raw1[7:0];
            p2_q       <= raw2[7:0];
            svc_q      <= raw_svc;
            for (int i = 0; i < 2; i++) begin
                coin_q[i] <= raw_coin[i] | coin_rise[i] | (cnt[i] != '0);
                if (coin_rise[i])
                    cnt[i] <= RELOAD;
                else if (cnt[i] != '0)
                    cnt[i] <= cnt[i] - 1'b1;
            end
        end
    end

    assign io.player1 = {pause_q[0], coin_q[0], p1_q};
    assign io.player2 = {pause_q[1], coin_q[1], p2_q};
    assign io.service = svc_q;
endmodule

// File: tb/tb_input_mapper.sv
// Directed bench for input_mapper with a short coin stretch.
// Expected values are hand-derived from the key/joystick map.
module tb_input_mapper;
    logic clk = 1'b0;
    logic rst_n;
    logic tgl;
    int   n_cmp = 0;
    int   n_err = 0;
    int   high;

    input_mapper_if bus ();

    input_mapper #(
        .COIN_PULSE_CYCLES(8),
        .PAUSE_TOGGLE(1'b1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .io(bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++)
            tick();
    endtask

    task automatic send_key(input logic make, input logic [7:0] code);
        tgl = ~tgl;
        bus.ps2_key = {tgl, make, 1'b0, code};
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        tgl = 1'b1;
        rst_n = 1'b0;
        bus.ps2_key = 11'h675;
        bus.joystick_0 = '0;
        bus.joystick_1 = '0;
        ticks(3);
        chk("rst_p1", 32'(bus.player1), 32'h0);
        chk("rst_p2", 32'(bus.player2), 32'h0);
        chk("rst_svc", 32'(bus.service), 32'h0);
        rst_n = 1'b1;
        ticks(2);
        chk("no_evt", 32'(bus.player1), 32'h0);

        send_key(1'b1, 8'h75);
        tick();
        chk("up_lat1", 32'(bus.player1), 32'h0);
        tick();
        chk("up_make", 32'(bus.player1), 32'h001);
        send_key(1'b0, 8'h75);
        tick();
        chk("up_brk1", 32'(bus.player1), 32'h001);
        tick();
        chk("up_brk", 32'(bus.player1), 32'h0);

        bus.joystick_0 = 32'h0F9;
        tick();
        chk("joy_map", 32'(bus.player1), 32'h0F9);
        bus.joystick_0 = 32'h006;
        tick();
        chk("joy_dl", 32'(bus.player1), 32'h006);
        bus.joystick_0 = '0;
        tick();

        bus.joystick_0 = 32'h100;
        tick();
        bus.joystick_0 = '0;
        high = 0;
        for (int i = 0; i < 20; i++) begin
            high += int'(bus.player1[8]);
            tick();
        end
        chk("coin_width", 32'(high), 32'd8);

        bus.joystick_0 = 32'h100;
        tick();
        bus.joystick_0 = '0;
        ticks(4);
        chk("coin_mid", 32'(bus.player1[8]), 32'h1);
        bus.joystick_0 = 32'h100;
        tick();
        bus.joystick_0 = '0;
        high = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            high += int'(bus.player1[8]);
        end
        chk("coin_retrig", 32'(high), 32'd7);

        bus.joystick_0 = 32'h100;
        ticks(12);
        chk("coin_held", 32'(bus.player1[8]), 32'h1);
        bus.joystick_0 = '0;
        ticks(10);
        chk("coin_off", 32'(bus.player1[8]), 32'h0);

        send_key(1'b1, 8'h4D);
        tick();
        chk("pause_lat", 32'(bus.player1[9]), 32'h0);
        tick();
        chk("pause_on", 32'(bus.player1[9]), 32'h1);
        send_key(1'b0, 8'h4D);
        ticks(2);
        chk("pause_rel", 32'(bus.player1[9]), 32'h1);
        send_key(1'b1, 8'h4D);
        ticks(2);
        chk("pause_off", 32'(bus.player1[9]), 32'h0);
        send_key(1'b0, 8'h4D);
        ticks(2);

        send_key(1'b1, 8'h4D);
        bus.joystick_0 = 32'h200;
        ticks(3);
        chk("pause_both", 32'(bus.player1[9]), 32'h1);
        send_key(1'b0, 8'h4D);
        bus.joystick_0 = '0;
        ticks(2);
        chk("pause_both_rel", 32'(bus.player1[9]), 32'h1);

        bus.joystick_1 = 32'h200;
        tick();
        bus.joystick_1 = '0;
        tick();
        chk("p2_pause", 32'(bus.player2[9]), 32'h1);
        chk("p1_pause_kept", 32'(bus.player1[9]), 32'h1);

        bus.joystick_1 = 32'h010;
        send_key(1'b1, 8'h1C);
        ticks(2);
        chk("mix_on", 32'(bus.player2[4]), 32'h1);
        send_key(1'b0, 8'h1C);
        ticks(2);
        chk("mix_brk", 32'(bus.player2[4]), 32'h1);
        bus.joystick_1 = '0;
        tick();
        chk("mix_off", 32'(bus.player2[4]), 32'h0);

        send_key(1'b1, 8'h2D);
        ticks(2);
        chk("p2_up", 32'(bus.player2[3:0]), 32'h1);
        send_key(1'b0, 8'h2D);
        ticks(2);

        bus.joystick_1 = 32'h100;
        tick();
        bus.joystick_1 = '0;
        ticks(2);
        chk("p2_coin", 32'(bus.player2[8]), 32'h1);
        rst_n = 1'b0;
        tick();
        chk("rst_mid_p2", 32'(bus.player2), 32'h0);
        chk("rst_mid_p1", 32'(bus.player1), 32'h0);
        rst_n = 1'b1;
        tick();
        chk("rst_abort", 32'(bus.player2[8]), 32'h0);
        tick();

        send_key(1'b1, 8'h5A);
        ticks(2);
        chk("unk_p1", 32'(bus.player1), 32'h0);
        chk("unk_p2", 32'(bus.player2), 32'h0);
        chk("unk_svc", 32'(bus.service), 32'h0);

        send_key(1'b1, 8'h46);
        ticks(2);
        chk("svc1", 32'(bus.service), 32'h1);
        send_key(1'b1, 8'h45);
        ticks(2);
        chk("svc12", 32'(bus.service), 32'h3);
        send_key(1'b0, 8'h46);
        tick();
        send_key(1'b0, 8'h45);
        tick();
        chk("b2b_1", 32'(bus.service), 32'h2);
        tick();
        chk("b2b_2", 32'(bus.service), 32'h0);

        bus.joystick_0 = 32'h400;
        tick();
        chk("joy_svc1", 32'(bus.service), 32'h1);
        bus.joystick_0 = '0;
        bus.joystick_1 = 32'h400;
        tick();
        chk("joy_svc2", 32'(bus.service), 32'h2);
        bus.joystick_1 = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
